// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with a single ID/EX pipeline register.
// Decodes the fetched word, reads the register file combinationally, detects
// load-use hazards against the instruction currently held in ID/EX and
// inserts a bubble when one is found.
// Optional feature: define RV32M_EN to decode the M extension (OP with
// funct7=0000001) as a legal mul/div operation; otherwise it is illegal and
// ex_muldiv is constant 0.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  // fetch side
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  // register file
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  // pipeline control
  input  logic            flush,
  input  logic            ex_ready,
  // ID/EX slot
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_reg_wr,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_alu_src_imm,
  output logic            ex_pc_src,
  output logic            ex_muldiv,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  // Control bits travelling with the instruction; all zero in a bubble.
  // pc_src: ALU operand A is the PC (AUIPC, JAL).
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jump;
    logic alu_src_imm;
    logic pc_src;
`ifdef RV32M_EN
    logic muldiv;
`endif
    logic illegal;
  } ctl_t;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  ctl_t            dec_ctl;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            use_rs1, use_rs2;
  logic            hazard;

  ctl_t            ex_ctl;

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  // Sign-extended immediates for every format; B and J are halfword aligned.
  assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){if_instr[31]}}, if_instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  // Opcode decode into control bits, immediate, ALU op and source usage.
  always_comb begin
    dec_ctl    = '0;
    dec_imm    = '0;
    dec_alu_op = 4'b0000;
    use_rs1    = 1'b1;
    use_rs2    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_ctl.reg_wr      = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_imm             = imm_u;
        use_rs1             = 1'b0;
      end
      OPC_AUIPC: begin
        dec_ctl.reg_wr      = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_ctl.pc_src      = 1'b1;
        dec_imm             = imm_u;
        use_rs1             = 1'b0;
      end
      OPC_JAL: begin
        dec_ctl.reg_wr      = 1'b1;
        dec_ctl.jump        = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_ctl.pc_src      = 1'b1;
        dec_imm             = imm_j;
        use_rs1             = 1'b0;
      end
      OPC_JALR: begin
        dec_ctl.reg_wr      = 1'b1;
        dec_ctl.jump        = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_imm             = imm_i;
      end
      OPC_BRANCH: begin
        dec_ctl.branch = 1'b1;
        dec_imm        = imm_b;
        use_rs2        = 1'b1;
      end
      OPC_LOAD: begin
        dec_ctl.reg_wr      = 1'b1;
        dec_ctl.mem_rd      = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_imm             = imm_i;
      end
      OPC_STORE: begin
        dec_ctl.mem_wr      = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_imm             = imm_s;
        use_rs2             = 1'b1;
      end
      OPC_OPIMM: begin
        dec_ctl.reg_wr      = 1'b1;
        dec_ctl.alu_src_imm = 1'b1;
        dec_imm             = imm_i;
        // instr[30] selects SRAI vs SRLI only; elsewhere it is immediate data
        dec_alu_op          = {(funct3 == 3'b101) & if_instr[30], funct3};
      end
      OPC_OP: begin
        use_rs2 = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          dec_ctl.reg_wr = 1'b1;
          dec_ctl.muldiv = 1'b1;
          dec_alu_op     = {1'b0, funct3};
`else
          dec_ctl.illegal = 1'b1;
`endif
        end else begin
          dec_ctl.reg_wr = 1'b1;
          dec_alu_op     = {if_instr[30], funct3};
        end
      end
      OPC_MISC: begin
        // FENCE retires as a NOP
      end
      default: begin
        dec_ctl.illegal = 1'b1;
      end
    endcase
    // writes to x0 are dropped at decode so later stages need no rd check
    if (rd == 5'd0) dec_ctl.reg_wr = 1'b0;
  end

  // Load-use: the load in ID/EX produces data the incoming instruction reads.
  assign hazard = if_valid & ex_valid & ex_mem_rd & (ex_rd != 5'd0) &
                  ((use_rs1 & (rs1_addr == ex_rd)) |
                   (use_rs2 & (rs2_addr == ex_rd)));

  assign id_ready = ex_ready & ~hazard;

  // ID/EX register: reset > flush > hold on stall > bubble on hazard > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctl      <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_alu_op   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctl   <= '0;
    end else if (!ex_ready) begin
      // execute is stalled: the slot holds as-is
    end else if (hazard) begin
      ex_valid <= 1'b0;
      ex_ctl   <= '0;
    end else begin
      ex_valid    <= if_valid;
      ex_ctl      <= if_valid ? dec_ctl : '0;
      ex_pc       <= if_pc;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= dec_imm;
      ex_rd       <= rd;
      ex_funct3   <= funct3;
      ex_alu_op   <= dec_alu_op;
    end
  end

  assign ex_reg_wr      = ex_ctl.reg_wr;
  assign ex_mem_rd      = ex_ctl.mem_rd;
  assign ex_mem_wr      = ex_ctl.mem_wr;
  assign ex_branch      = ex_ctl.branch;
  assign ex_jump        = ex_ctl.jump;
  assign ex_alu_src_imm = ex_ctl.alu_src_imm;
  assign ex_pc_src      = ex_ctl.pc_src;
  assign ex_illegal     = ex_ctl.illegal;
`ifdef RV32M_EN
  assign ex_muldiv      = ex_ctl.muldiv;
`else
  assign ex_muldiv      = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Each accepted
// instruction pushes its hand-computed expected ID/EX contents; the entry is
// popped and compared when execute consumes the slot.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump;
  logic        ex_alu_src_imm, ex_pc_src, ex_muldiv, ex_illegal;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_pc_src(ex_pc_src), .ex_muldiv(ex_muldiv), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // ctl order: {reg_wr,mem_rd,mem_wr,branch,jump,alu_src_imm,pc_src,muldiv,illegal}
  localparam logic [8:0] C_ALUI = 9'b100001000;
  localparam logic [8:0] C_LOAD = 9'b110001000;
  localparam logic [8:0] C_R    = 9'b100000000;
  localparam logic [8:0] C_ILL  = 9'b000000001;
`ifdef RV32M_EN
  localparam logic [8:0] C_MUL  = 9'b100000010;
`else
  localparam logic [8:0] C_MUL  = C_ILL;
`endif

  localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_LW3   = 32'h0000A183; // lw x3,0(x1)
  localparam logic [31:0] I_ADD   = 32'h00218233; // add x4,x3,x2
  localparam logic [31:0] I_LUI   = 32'h123453B7; // lui x7,0x12345
  localparam logic [31:0] I_ANDI  = 32'hFFF37293; // andi x5,x6,-1

  typedef struct {
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  aop;
    logic [8:0]  ctl;
    bit          ck_imm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic [3:0] aop, input logic [8:0] ctl, input bit ck);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.f3 = f3; e.aop = aop; e.ctl = ctl;
    e.ck_imm = ck; e.r1 = '0; e.r2 = '0;
    return e;
  endfunction

  function automatic logic [8:0] ctl_vec();
    return {ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
            ex_alu_src_imm, ex_pc_src, ex_muldiv, ex_illegal};
  endfunction

  // One cycle: drive inputs, check at the falling edge, update the scoreboard.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rs,
                      input logic exp_idr, input exp_t e_in);
    exp_t e, got;
    e = e_in;
    if_valid = v; if_instr = ins; if_pc = pc;
    rs1_data = $urandom; rs2_data = $urandom;
    ex_ready = rdy; flush = fl; reset = rs;
    e.r1 = rs1_data; e.r2 = rs2_data;
    @(negedge clk);
    chk("ex_valid", ex_valid, q.size() != 0);
    if (!ex_valid) chk("bubble_ctl", ctl_vec(), 0);
    chk("id_ready", id_ready, exp_idr);
    chk("rs1_addr", rs1_addr, ins[19:15]);
    chk("rs2_addr", rs2_addr, ins[24:20]);
    if (q.size() != 0 && rdy && !fl && !rs) begin
      got = q.pop_front();
      chk("ex_pc", ex_pc, got.pc);
      chk("ex_rs1_data", ex_rs1_data, got.r1);
      chk("ex_rs2_data", ex_rs2_data, got.r2);
      if (got.ck_imm) chk("ex_imm", ex_imm, got.imm);
      chk("ex_rd", ex_rd, got.rd);
      chk("ex_funct3", ex_funct3, got.f3);
      chk("ex_alu_op", ex_alu_op, got.aop);
      chk("ex_ctl", ctl_vec(), got.ctl);
    end
    if (fl || rs) q.delete();
    if (v && exp_idr && !fl && !rs) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t nx;

  initial begin
    nx = mk(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rs1_data = '0; rs2_data = '0; flush = 1'b0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    step(0, 32'h0, 32'h0, 1, 0, 0, 1, nx);
    // addi x5,x0,-1
    step(1, I_ADDI, 32'h100, 1, 0, 0, 1, mk(32'h100, 32'hFFFFFFFF, 5, 0, 4'h0, C_ALUI, 1));
    // load-use: lw x3 then add x4,x3,x2 -> one bubble
    step(1, I_LW3, 32'h104, 1, 0, 0, 1, mk(32'h104, 0, 3, 2, 0, C_LOAD, 1));
    step(1, I_ADD, 32'h108, 1, 0, 0, 0, nx);
    step(1, I_ADD, 32'h108, 1, 0, 0, 1, mk(32'h108, 0, 4, 0, 4'h0, C_R, 0));
    // load to x0 never stalls
    step(1, 32'h0000A003, 32'h10C, 1, 0, 0, 1, mk(32'h10C, 0, 0, 2, 0, 9'b010001000, 1));
    step(1, 32'h00200233, 32'h110, 1, 0, 0, 1, mk(32'h110, 0, 4, 0, 4'h0, C_R, 0));
    // load-use through rs2 of a store
    step(1, I_LW3, 32'h114, 1, 0, 0, 1, mk(32'h114, 0, 3, 2, 0, C_LOAD, 1));
    step(1, 32'h0030A023, 32'h118, 1, 0, 0, 0, nx);
    step(1, 32'h0030A023, 32'h118, 1, 0, 0, 1, mk(32'h118, 0, 0, 2, 0, 9'b001001000, 1));
    // immediate formats and ALU op selection
    step(1, I_LUI, 32'h11C, 1, 0, 0, 1, mk(32'h11C, 32'h12345000, 7, 5, 0, C_ALUI, 1));
    step(1, 32'hFFFFF097, 32'h120, 1, 0, 0, 1, mk(32'h120, 32'hFFFFF000, 1, 7, 0, 9'b100001100, 1));
    step(1, 32'hFFDFF0EF, 32'h124, 1, 0, 0, 1, mk(32'h124, 32'hFFFFFFFC, 1, 7, 0, 9'b100011100, 1));
    step(1, 32'h00808067, 32'h128, 1, 0, 0, 1, mk(32'h128, 32'h8, 0, 0, 0, 9'b000011000, 1));
    step(1, 32'hFE208CE3, 32'h12C, 1, 0, 0, 1, mk(32'h12C, 32'hFFFFFFF8, 25, 0, 0, 9'b000100000, 1));
    step(1, 32'hFE20AE23, 32'h130, 1, 0, 0, 1, mk(32'h130, 32'hFFFFFFFC, 28, 2, 0, 9'b001001000, 1));
    step(1, 32'h40335293, 32'h134, 1, 0, 0, 1, mk(32'h134, 32'h403, 5, 5, 4'hD, C_ALUI, 1));
    step(1, I_ANDI, 32'h138, 1, 0, 0, 1, mk(32'h138, 32'hFFFFFFFF, 5, 7, 4'h7, C_ALUI, 1));
    step(1, 32'h40838333, 32'h13C, 1, 0, 0, 1, mk(32'h13C, 0, 6, 0, 4'h8, C_R, 0));
    step(1, 32'h0FF0000F, 32'h140, 1, 0, 0, 1, mk(32'h140, 0, 0, 0, 0, 9'b0, 0));
    // mul x1,x2,x3 and an all-ones word
    step(1, 32'h023100B3, 32'h144, 1, 0, 0, 1, mk(32'h144, 0, 1, 0, 0, C_MUL, 0));
    step(1, 32'hFFFFFFFF, 32'h148, 1, 0, 0, 1, mk(32'h148, 0, 31, 7, 0, C_ILL, 0));
    // three-cycle stall: slot must hold unchanged until consumed
    step(1, 32'h40838333, 32'h14C, 1, 0, 0, 1, mk(32'h14C, 0, 6, 0, 4'h8, C_R, 0));
    for (int i = 0; i < 3; i++) step(1, I_ADDI, 32'h150, 0, 0, 0, 0, nx);
    step(1, I_ADDI, 32'h150, 1, 0, 0, 1, mk(32'h150, 32'hFFFFFFFF, 5, 0, 0, C_ALUI, 1));
    // stall with flush in cycle 2 squashes the held slot
    step(1, I_ANDI, 32'h154, 0, 0, 0, 0, nx);
    step(1, I_ANDI, 32'h154, 0, 1, 0, 0, nx);
    step(1, I_ANDI, 32'h154, 0, 0, 0, 0, nx);
    step(1, I_ANDI, 32'h154, 1, 0, 0, 1, mk(32'h154, 32'hFFFFFFFF, 5, 7, 4'h7, C_ALUI, 1));
    // flush coinciding with a load-use hazard
    step(1, I_LW3, 32'h158, 1, 0, 0, 1, mk(32'h158, 0, 3, 2, 0, C_LOAD, 1));
    step(1, I_ADD, 32'h15C, 1, 1, 0, 0, nx);
    step(1, I_ADD, 32'h15C, 1, 0, 0, 1, mk(32'h15C, 0, 4, 0, 0, C_R, 0));
    // reset mid-stream
    step(1, I_ADDI, 32'h160, 1, 0, 0, 1, mk(32'h160, 32'hFFFFFFFF, 5, 0, 0, C_ALUI, 1));
    step(1, I_LUI, 32'h164, 1, 0, 1, 1, nx);
    step(0, 32'h0, 32'h0, 1, 0, 0, 1, nx);
    // reset mid-stall discards the held slot
    step(1, I_ADDI, 32'h168, 1, 0, 0, 1, mk(32'h168, 32'hFFFFFFFF, 5, 0, 0, C_ALUI, 1));
    step(1, I_LUI, 32'h16C, 0, 0, 0, 0, nx);
    step(1, I_LUI, 32'h16C, 0, 0, 1, 0, nx);
    step(1, I_LUI, 32'h16C, 1, 0, 0, 1, mk(32'h16C, 32'h12345000, 7, 5, 0, C_ALUI, 1));
    step(0, 32'h0, 32'h0, 1, 0, 0, 1, nx);
    step(0, 32'h0, 32'h0, 1, 0, 0, 1, nx);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
